// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and encodings for the interrupt controller
package intr_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - interrupt presentation handshake (valid/id/ack)
interface intr_ctrl_if #(
  parameter int ID_W = 3
) ();

  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;

  modport master (
    output irq_valid,
    output irq_id,
    input  irq_ack
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    output irq_ack
  );

endinterface

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - multi-flop synchronizer for one asynchronous interrupt line
module intr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: synchronize, latch pending, present lowest index
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] intr,
  input  logic [NUM_CH-1:0] intr_en,
  input  logic [NUM_CH-1:0] intr_mode,
  intr_ctrl_if.master       irq,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  logic [NUM_CH-1:0] sync;
  logic [NUM_CH-1:0] sync_d;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] ovr_q;

  state_t          state;
  state_t          state_n;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_n;
  logic [ID_W-1:0] low_id;
  logic            any_pend;
  logic            accept;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_sync
      intr_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (intr[g]),
        .q     (sync[g])
      );
    end
  endgenerate

  assign edge_det = sync & ~sync_d;
  assign accept   = (state == PRESENT) && irq.irq_ack;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr[i] = accept && (id_q == ID_W'(i));
    end
  end

  // A new edge wins over a same-cycle ack so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      sync_d <= sync;
      for (int i = 0; i < NUM_CH; i++) begin
        if (intr_mode[i] == MODE_EDGE) begin
          pend_q[i] <= (pend_q[i] & ~clr[i]) | (edge_det[i] & intr_en[i]);
        end else begin
          pend_q[i] <= sync[i] & intr_en[i];
        end
        if (clr[i]) begin
          ovr_q[i] <= 1'b0;
        end else if ((intr_mode[i] == MODE_EDGE) && edge_det[i] && intr_en[i] && pend_q[i]) begin
          ovr_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    low_id   = '0;
    any_pend = |pend_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_n;
      id_q  <= id_n;
    end
  end

  // The presented id is frozen for the whole PRESENT phase; no preemption.
  always_comb begin
    state_n = state;
    id_n    = id_q;
    case (state)
      IDLE: begin
        if (any_pend) begin
          state_n = PRESENT;
          id_n    = low_id;
        end
      end
      PRESENT: begin
        if (irq.irq_ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign irq.irq_valid = (state == PRESENT);
  assign irq.irq_id    = id_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl
module tb_intr_ctrl;

  localparam int NUM_CH = 8;
  localparam int SS     = 2;
  localparam int ID_W   = 3;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] intr;
  logic [NUM_CH-1:0] intr_en;
  logic [NUM_CH-1:0] intr_mode;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  intr_ctrl_if #(.ID_W(ID_W)) bif ();

  intr_ctrl #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SS),
    .ID_W        (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .intr      (intr),
    .intr_en   (intr_en),
    .intr_mode (intr_mode),
    .irq       (bif),
    .pending   (pending),
    .overrun   (overrun)
  );

  typedef struct {
    int   ch;
    logic mode;
    logic en;
    int   pulse;
    logic exp;
  } vec_t;

  vec_t tbl[6];
  int   sb[$];
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic serve(input string nm);
    int n;
    int e;
    n = 0;
    while (!bif.irq_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_valid"}, 32'(bif.irq_valid), 32'd1);
    if (bif.irq_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_unexpected: got id %0d expected no presentation", nm, bif.irq_id);
      end else begin
        e = sb.pop_front();
        chk({nm, "_id"}, 32'(bif.irq_id), 32'(e));
      end
      bif.irq_ack = 1'b1;
      step();
      bif.irq_ack = 1'b0;
      chk({nm, "_drop"}, 32'(bif.irq_valid), 32'd0);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    intr        = '0;
    intr_en     = '1;
    intr_mode   = '1;
    bif.irq_ack = 1'b0;

    tbl[0] = '{ch: 3, mode: 1'b1, en: 1'b1, pulse: 3, exp: 1'b1};
    tbl[1] = '{ch: 7, mode: 1'b1, en: 1'b1, pulse: 1, exp: 1'b1};
    tbl[2] = '{ch: 0, mode: 1'b1, en: 1'b1, pulse: 4, exp: 1'b1};
    tbl[3] = '{ch: 1, mode: 1'b0, en: 1'b1, pulse: 1, exp: 1'b1};
    tbl[4] = '{ch: 5, mode: 1'b0, en: 1'b0, pulse: 3, exp: 1'b0};
    tbl[5] = '{ch: 6, mode: 1'b1, en: 1'b0, pulse: 2, exp: 1'b0};

    #1;
    chk("rst_valid",   32'(bif.irq_valid), 32'd0);
    chk("rst_id",      32'(bif.irq_id),    32'd0);
    chk("rst_pending", 32'(pending),       32'd0);
    chk("rst_overrun", 32'(overrun),       32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single-channel vectors: latency, enable gating, level vs edge.
    for (int v = 0; v < 6; v++) begin
      intr_mode             = '1;
      intr_mode[tbl[v].ch]  = tbl[v].mode;
      intr_en               = '1;
      intr_en[tbl[v].ch]    = tbl[v].en;
      step();
      intr[tbl[v].ch] = 1'b1;
      if (tbl[v].exp) sb.push_back(tbl[v].ch);
      for (int c = 1; c <= SS + 2; c++) begin
        step();
        if (c == tbl[v].pulse) intr[tbl[v].ch] = 1'b0;
        if (c == SS + 1) chk($sformatf("v%0d_early", v), 32'(bif.irq_valid), 32'd0);
        if (c == SS + 2) chk($sformatf("v%0d_lat", v), 32'(bif.irq_valid), 32'(tbl[v].exp));
      end
      if (tbl[v].exp) begin
        serve($sformatf("v%0d", v));
        chk($sformatf("v%0d_pend_clr", v), 32'(pending[tbl[v].ch]), 32'd0);
      end else begin
        chk($sformatf("v%0d_no_pend", v), 32'(pending), 32'd0);
      end
      intr = '0;
      repeat (SS + 3) step();
      chk($sformatf("v%0d_ovr", v), 32'(overrun), 32'd0);
    end

    // Re-enabling a channel must not resurrect a discarded edge.
    intr_en   = '1;
    intr_mode = '1;
    for (int c = 0; c < SS + 3; c++) begin
      step();
      chk("reen_valid", 32'(bif.irq_valid), 32'd0);
    end
    chk("reen_pend", 32'(pending), 32'd0);

    // Simultaneous edges on ch5 and ch1: lowest first, one-cycle gap.
    intr[5] = 1'b1;
    intr[1] = 1'b1;
    sb.push_back(1);
    sb.push_back(5);
    step();
    intr = '0;
    serve("pair_a");
    step();
    chk("pair_gap", 32'(bif.irq_valid), 32'd1);
    serve("pair_b");
    chk("pair_pend", 32'(pending), 32'd0);
    repeat (SS + 3) step();

    // Level ch2 held high: re-presented after each ack with a one-cycle gap.
    intr_mode[2] = 1'b0;
    intr[2]      = 1'b1;
    for (int r = 0; r < 8; r++) begin
      sb.push_back(2);
      if (r > 0) begin
        step();
        chk("lvl_gap", 32'(bif.irq_valid), 32'd1);
      end
      serve("lvl");
    end
    intr[2] = 1'b0;
    sb.push_back(2);
    for (int c = 1; c <= SS + 1; c++) begin
      step();
      if (c == SS) chk("lvl_hold_pend", 32'(pending[2]), 32'd1);
      if (c == SS + 1) begin
        chk("lvl_fall_pend", 32'(pending[2]), 32'd0);
        chk("lvl_no_retract", 32'(bif.irq_valid), 32'd1);
      end
    end
    serve("lvl_last");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("lvl_quiet", 32'(bif.irq_valid), 32'd0);
    end
    intr_mode = '1;
    repeat (SS + 2) step();

    // Two edges on ch4 before ack set overrun; ack clears both.
    intr[4] = 1'b1;
    step();
    intr[4] = 1'b0;
    step();
    intr[4] = 1'b1;
    step();
    intr[4] = 1'b0;
    repeat (3) step();
    chk("ovr_set",  32'(overrun[4]), 32'd1);
    chk("ovr_pend", 32'(pending[4]), 32'd1);
    sb.push_back(4);
    serve("ovr");
    chk("ovr_clr",      32'(overrun[4]), 32'd0);
    chk("ovr_pend_clr", 32'(pending[4]), 32'd0);
    repeat (SS + 3) step();

    // Reset while presenting ch0, intr[0] held high through reset.
    intr[0] = 1'b1;
    for (int n = 0; n < 20 && !bif.irq_valid; n++) step();
    chk("rp_present", 32'(bif.irq_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rp_valid",   32'(bif.irq_valid), 32'd0);
    chk("rp_id",      32'(bif.irq_id),    32'd0);
    chk("rp_pending", 32'(pending),       32'd0);
    chk("rp_overrun", 32'(overrun),       32'd0);
    step();
    step();
    rst_n = 1'b1;
    sb.push_back(0);
    for (int c = 1; c <= SS + 2; c++) begin
      step();
      if (c == SS + 1) chk("rp_early", 32'(bif.irq_valid), 32'd1 - 32'd1);
      if (c == SS + 2) chk("rp_lat",   32'(bif.irq_valid), 32'd1);
    end
    intr[0] = 1'b0;
    serve("rp");
    repeat (SS + 3) step();
    chk("final_valid", 32'(bif.irq_valid), 32'd0);
    chk("sb_empty",    32'(sb.size()),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
